// File: rtl/mips_check_pkg.sv
// Shared definitions for the post-run sort result checker.
// Holds the scanner state encoding and the default result-region geometry
// that matches the bubble-sort program image loaded into the MIPS32 core.
package mips_check_pkg;

    localparam int DW_DEF   = 32;
    localparam int BASE_DEF = 100;
    localparam int LEN_DEF  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sort_check_acc.sv
// Per-word accumulator for the sort result checker.
// Folds each returned word into checksum, min, max and the descending-pair
// statistics. A clear pulse returns every result to its idle value.
//   clk1            : clock
//   rst             : synchronous active-high reset
//   clear_i         : restart accumulation (takes priority over valid_i)
//   valid_i         : word_i carries a returned memory word this cycle
//   first_i         : word_i is word 0 of the region (no predecessor)
//   word_i          : returned data word
//   prev_o          : last accumulated word
//   checksum_o      : running sum mod 2^DW
//   min_o / max_o   : running unsigned minimum / maximum
//   err_count_o     : number of descending adjacent pairs so far
//   first_err_idx_o : index of the first descending word, 0 if none
module sort_check_acc
    import mips_check_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = 5
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic          first_i,
    input  logic [DW-1:0] word_i,
    output logic [DW-1:0] prev_o,
    output logic [DW-1:0] checksum_o,
    output logic [DW-1:0] min_o,
    output logic [DW-1:0] max_o,
    output logic [CW-1:0] err_count_o,
    output logic [CW-1:0] first_err_idx_o
);

    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] max_q, max_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [CW-1:0] first_err_q, first_err_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          desc;

    assign desc = valid_i && !first_i && (word_i < prev_q);

    always_comb begin
        prev_d      = prev_q;
        checksum_d  = checksum_q;
        min_d       = min_q;
        max_d       = max_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        idx_d       = idx_q;
        if (clear_i) begin
            prev_d      = '0;
            checksum_d  = '0;
            min_d       = '1;
            max_d       = '0;
            err_count_d = '0;
            first_err_d = '0;
            idx_d       = '0;
        end else if (valid_i) begin
            checksum_d = checksum_q + word_i;
            if (word_i < min_q) min_d = word_i;
            if (word_i > max_q) max_d = word_i;
            prev_d = word_i;
            idx_d  = idx_q + CW'(1);
            if (desc) begin
                err_count_d = err_count_q + CW'(1);
                // Only the first descending word records its index.
                if (err_count_q == '0) first_err_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            prev_q      <= '0;
            checksum_q  <= '0;
            min_q       <= '1;
            max_q       <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            idx_q       <= '0;
        end else begin
            prev_q      <= prev_d;
            checksum_q  <= checksum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            idx_q       <= idx_d;
        end
    end

    assign prev_o          = prev_q;
    assign checksum_o      = checksum_q;
    assign min_o           = min_q;
    assign max_o           = max_q;
    assign err_count_o     = err_count_q;
    assign first_err_idx_o = first_err_q;

endmodule

// File: rtl/sort_result_checker.sv
// Post-run result scanner for the pipelined MIPS32 core.
// On a rising edge of halted it reads LEN words starting at BASE through a
// read-only port (data one cycle after the strobe), checks they are in
// non-decreasing unsigned order and reports error statistics, checksum and
// min/max.
//   clk1          : clock
//   rst           : synchronous active-high reset
//   halted        : core HALTED flag; its rising edge starts a scan
//   mem_rd_en     : read strobe
//   mem_rd_addr   : read word address (holds when mem_rd_en=0)
//   mem_rd_data   : read data, valid one cycle after mem_rd_en
//   busy / done   : scan in progress / scan complete, results valid
//   pass          : region ordered, qualified by done
//   err_count     : number of descending adjacent pairs
//   first_err_idx : lowest descending index, 0 if none
//   checksum      : sum of all words mod 2^DW
//   min_val       : unsigned minimum
//   max_val       : unsigned maximum
//
// state | meaning
// IDLE  | waiting for a halted rising edge
// ISSUE | one read per cycle, BASE..BASE+LEN-1
// DRAIN | last read outstanding, consume its data
// DONE  | results valid and held; new start edge restarts
module sort_result_checker
    import mips_check_pkg::*;
#(
    parameter int AW   = 10,
    parameter int DW   = DW_DEF,
    parameter int BASE = BASE_DEF,
    parameter int LEN  = LEN_DEF,
    parameter int CW   = $clog2(LEN + 1)
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] first_err_idx,
    output logic [DW-1:0] checksum,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val
);

    state_e        state_q, state_d;
    logic          halted_q;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          first_q, first_d;
    logic          valid_q;
    logic          start;
    logic          clear;
    logic          last_desc;
    logic [DW-1:0] prev;

    assign start = halted && !halted_q;

    // The final word is compared on the same edge that raises done, so pass
    // must fold in that word's comparison alongside the registered count.
    assign last_desc = valid_q && !first_q && (mem_rd_data < prev);

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    rd_en_d = 1'b1;
                    addr_d  = AW'(BASE);
                    rem_d   = CW'(LEN - 1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - CW'(1);
                end
            end
            DRAIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count == '0) && !last_desc;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        first_d = first_q;
        if (clear)        first_d = 1'b1;
        else if (valid_q) first_d = 1'b0;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            first_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            first_q  <= first_d;
            valid_q  <= rd_en_q;
        end
    end

    sort_check_acc #(
        .DW (DW),
        .CW (CW)
    ) u_acc (
        .clk1            (clk1),
        .rst             (rst),
        .clear_i         (clear),
        .valid_i         (valid_q),
        .first_i         (first_q),
        .word_i          (mem_rd_data),
        .prev_o          (prev),
        .checksum_o      (checksum),
        .min_o           (min_val),
        .max_o           (max_val),
        .err_count_o     (err_count),
        .first_err_idx_o (first_err_idx)
    );

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule
